serial_adder_seq: RTL and testbench

- Bit-serial add/subtract engine for the image-filter datapath.
- Accepts two WIDTH-bit operands over a valid/ready handshake and streams one bit per cycle, LSB first, through a single full-adder slice with a registered carry.
- Returns the WIDTH-bit result, carry-out and signed-overflow flag over a second valid/ready handshake.
- Sits around the 1-bit full adder: supplies its A/B/Cin each cycle and consumes its Sum/Cout.

---
 rtl/serial_adder_seq.sv | 130 +++++++++++++
 tb/tb_serial_adder_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_seq.sv
// Bit-serial add/subtract engine: one full-adder slice with a registered carry,
// LSB first, framed by valid/ready handshakes on operands and result.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-2:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] res_shift;
  logic             last_bit;

  full_adder u_fa (
    .a   (sa[0]),
    .b   (sb[0]),
    .cin (carry),
    .s   (fa_s),
    .co  (fa_co)
  );

  // New sum bit enters from the MSB side; after WIDTH shifts bit 0 is the LSB.
  assign res_shift = {fa_s, res};
  assign last_bit  = (cnt == LAST);

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_bit)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            sa    <= a;
            sb    <= sub ? ~b : b;
            // Subtract is A + ~B + 1; the +1 rides in on the initial carry.
            carry <= sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          sa    <= {1'b0, sa[WIDTH-1:1]};
          sb    <= {1'b0, sb[WIDTH-1:1]};
          res   <= res_shift[WIDTH-1:1];
          carry <= fa_co;
          cnt   <= cnt + 1'b1;
          if (last_bit) begin
            sum_q  <= res_shift;
            cout_q <= fa_co;
            // carry holds the carry into the MSB on this edge.
            ovf_q  <= carry ^ fa_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Directed bench for serial_adder_seq: vector table plus hand-written
// sequences for backpressure, mid-run input changes and mid-run reset.

module tb_serial_adder_seq;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             busy;

  int errors = 0;
  int checks = 0;

  serial_adder_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, presents one operation for a single accepting edge.
  task automatic accept(input logic [7:0] av, input logic [7:0] bv, input logic sv);
    int n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    a = av; b = bv; sub = sv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid_drop", {31'd0, out_valid}, 32'd0);
  endtask

  int lat;
  logic [7:0] held_sum;

  initial begin
    vecs[0] = '{8'd200, 8'd100, 1'b0, 8'd44,  1'b1, 1'b0};
    vecs[1] = '{8'd100, 8'd50,  1'b0, 8'h96,  1'b0, 1'b1};
    vecs[2] = '{8'd5,   8'd7,   1'b1, 8'hFE,  1'b0, 1'b0};
    vecs[3] = '{8'h80,  8'h01,  1'b1, 8'h7F,  1'b1, 1'b1};
    vecs[4] = '{8'hFF,  8'h01,  1'b0, 8'h00,  1'b1, 1'b0};
    vecs[5] = '{8'h7F,  8'h01,  1'b0, 8'h80,  1'b0, 1'b1};
    vecs[6] = '{8'h00,  8'h00,  1'b1, 8'h00,  1'b1, 1'b0};
    vecs[7] = '{8'h55,  8'hAA,  1'b0, 8'hFF,  1'b0, 1'b0};
    vecs[8] = '{8'h00,  8'h01,  1'b1, 8'hFF,  1'b0, 1'b0};
    vecs[9] = '{8'h7F,  8'hFF,  1'b1, 8'h80,  1'b0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0;
    repeat (3) tick();

    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_sum",       {24'd0, sum},       32'd0);
    check("rst_cout",      {31'd0, cout},      32'd0);
    check("rst_overflow",  {31'd0, overflow},  32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      accept(vecs[i].a, vecs[i].b, vecs[i].sub);
      check("busy_after_accept", {31'd0, busy}, 32'd1);
      wait_done(lat);
      check("latency",  lat,                          WIDTH);
      check("sum",      {24'd0, sum},                 {24'd0, vecs[i].sum});
      check("cout",     {31'd0, cout},                {31'd0, vecs[i].cout});
      check("overflow", {31'd0, overflow},            {31'd0, vecs[i].ovf});
      release_out();
      check("sum_kept", {24'd0, sum},                 {24'd0, vecs[i].sum});
    end

    // Backpressure: result holds for 5 stalled cycles, then a new op that was
    // already offered during the release edge is taken only the edge after.
    accept(8'd200, 8'd100, 1'b0);
    wait_done(lat);
    check("bp_latency", lat, WIDTH);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_sum",       {24'd0, sum},       32'd44);
      check("bp_cout",      {31'd0, cout},      32'd1);
      check("bp_overflow",  {31'd0, overflow},  32'd0);
      check("bp_in_ready",  {31'd0, in_ready},  32'd0);
    end
    a = 8'd3; b = 8'd4; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_idle_out_valid", {31'd0, out_valid}, 32'd0);
    check("bp_idle_in_ready",  {31'd0, in_ready},  32'd1);
    check("bp_idle_sum",       {24'd0, sum},       32'd44);
    tick();
    in_valid = 1'b0;
    check("bp_next_busy", {31'd0, busy}, 32'd1);
    wait_done(lat);
    check("bp_next_latency", lat, WIDTH);
    check("bp_next_sum", {24'd0, sum}, 32'd7);
    release_out();

    // Inputs wiggle during RUN; only the originally accepted operands count.
    accept(8'd10, 8'd20, 1'b0);
    a = 8'hFF; b = 8'hFF; sub = 1'b1;
    tick();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 8'h0F; b = 8'hF0;
    wait_done(lat);
    check("run_ign_latency", lat, WIDTH - 2);
    check("run_ign_sum",  {24'd0, sum},  32'd30);
    check("run_ign_cout", {31'd0, cout}, 32'd0);
    release_out();
    tick();
    check("run_ign_no_second_busy",  {31'd0, busy},     32'd0);
    check("run_ign_no_second_ready", {31'd0, in_ready}, 32'd1);

    // Reset lands on the 4th RUN edge; the operation is discarded.
    held_sum = sum;
    check("pre_reset_sum_nonzero", {31'd0, (held_sum != 8'd0)}, 32'd1);
    accept(8'h55, 8'h11, 1'b0);
    repeat (3) tick();
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_busy",      {31'd0, busy},      32'd0);
    check("mid_rst_sum",       {24'd0, sum},       32'd0);
    for (int i = 0; i < WIDTH + 2; i++) begin
      tick();
      check("mid_rst_no_pulse", {31'd0, out_valid}, 32'd0);
    end
    accept(8'd1, 8'd1, 1'b0);
    wait_done(lat);
    check("post_rst_latency", lat, WIDTH);
    check("post_rst_sum",  {24'd0, sum},  32'd2);
    check("post_rst_cout", {31'd0, cout}, 32'd0);
    release_out();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
